// File: rtl/nl_lights_zone_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nl_lights_pkg
// Shared types and default constants for the multi-zone lights controller.
//   zone_state_t     : per-zone FSM state (OFF / TIMED / FORCED)
//   DEF_NZONES       : default zone count
//   DEF_HOLD_CYCLES  : default on-time after the last qualified movement
//   DEF_DIM_CYCLES   : default pre-off warning window (LIGHTS_DIM_EN builds)
// ---------------------------------------------------------------------------
package nl_lights_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    TIMED  = 2'd1,
    FORCED = 2'd2
  } zone_state_t;

  localparam int unsigned DEF_NZONES      = 32'd4;
  localparam int unsigned DEF_HOLD_CYCLES = 32'd16;
  localparam int unsigned DEF_DIM_CYCLES  = 32'd4;

endpackage : nl_lights_pkg

// File: rtl/nl_lights_zone_ctrl_if.sv
// ---------------------------------------------------------------------------
// nl_lights_zone_ctrl_if
// Bundles the sensor inputs and relay-driver outputs of the lights controller.
//   dark           : global ambient-dark indication
//   movement       : per-zone motion sensor level
//   force_on       : per-zone manual override
//   turn_on_lights : per-zone light enable (registered in the controller)
//   lights_on_cnt  : number of zones currently lit
//   dim_lights     : per-zone pre-off warning, present only when the
//                    LIGHTS_DIM_EN macro is defined
// Modports: master = sensor/test side, slave = controller side.
// ---------------------------------------------------------------------------
interface nl_lights_zone_ctrl_if #(
  parameter int unsigned NZONES = 32'd4
);

  localparam int unsigned CNT_W = $clog2(NZONES + 32'd1);

  logic              dark;
  logic [NZONES-1:0] movement;
  logic [NZONES-1:0] force_on;
  logic [NZONES-1:0] turn_on_lights;
  logic [CNT_W-1:0]  lights_on_cnt;
`ifdef LIGHTS_DIM_EN
  logic [NZONES-1:0] dim_lights;

  modport master (
    output dark, movement, force_on,
    input  turn_on_lights, lights_on_cnt, dim_lights
  );

  modport slave (
    input  dark, movement, force_on,
    output turn_on_lights, lights_on_cnt, dim_lights
  );
`else
  modport master (
    output dark, movement, force_on,
    input  turn_on_lights, lights_on_cnt
  );

  modport slave (
    input  dark, movement, force_on,
    output turn_on_lights, lights_on_cnt
  );
`endif

endinterface : nl_lights_zone_ctrl_if

// File: rtl/nl_lights_zone_ctrl_zone.sv
// ---------------------------------------------------------------------------
// nl_lights_zone
// One lighting zone: OFF / TIMED / FORCED state machine plus hold counter.
// Optional macro: LIGHTS_DIM_EN adds the dim_o pre-off warning output.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   dark_i       : global ambient-dark indication
//   movement_i   : this zone's motion sensor
//   force_on_i   : this zone's manual override
//   light_o      : registered light enable
//   light_d_o    : next value of light_o, lets the top keep its count aligned
//   dim_o        : registered pre-off warning (LIGHTS_DIM_EN only)
// ---------------------------------------------------------------------------
module nl_lights_zone
  import nl_lights_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
`ifdef LIGHTS_DIM_EN
  , parameter int unsigned DIM_CYCLES = DEF_DIM_CYCLES
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic dark_i,
  input  logic movement_i,
  input  logic force_on_i,
  output logic light_o,
  output logic light_d_o
`ifdef LIGHTS_DIM_EN
  , output logic dim_o
`endif
);

  localparam int unsigned     CNT_W   = $clog2(HOLD_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);

  zone_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             light_q;
  logic             qual_mv;

  assign qual_mv = dark_i & movement_i;

  // Next-state and counter update, override first, then qualified movement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_on_i) begin
      state_d = FORCED;
      cnt_d   = '0;
    end else if (qual_mv) begin
      // Retrigger simply reloads; the hold never accumulates.
      state_d = TIMED;
      cnt_d   = HOLD_LD;
    end else begin
      case (state_q)
        TIMED: begin
          if (!dark_i || (cnt_q == CNT_W'(1))) begin
            state_d = OFF;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        FORCED: begin
          state_d = OFF;
          cnt_d   = '0;
        end
        OFF: begin
          state_d = OFF;
          cnt_d   = '0;
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign light_d_o = (state_d != OFF);

  // State, counter and light-enable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      cnt_q   <= '0;
      light_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      light_q <= light_d_o;
    end
  end

  assign light_o = light_q;

`ifdef LIGHTS_DIM_EN
  localparam logic [CNT_W-1:0] DIM_LD = CNT_W'(DIM_CYCLES);

  logic dim_q;

  // Warning register, computed from next state so it lines up with light_o.
  always_ff @(posedge clk) begin
    if (reset) begin
      dim_q <= 1'b0;
    end else begin
      dim_q <= (state_d == TIMED) && (cnt_d <= DIM_LD);
    end
  end

  assign dim_o = dim_q;
`endif

endmodule : nl_lights_zone

// File: rtl/nl_lights_zone_ctrl.sv
// ---------------------------------------------------------------------------
// nl_lights_zone_ctrl
// Multi-zone timed lights controller: NZONES independent nl_lights_zone
// instances plus a registered count of lit zones.
// Optional macro: LIGHTS_DIM_EN enables the DIM_CYCLES parameter and the
// dim_lights output on the bus.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : nl_lights_zone_ctrl_if slave (sensor inputs, relay outputs)
// ---------------------------------------------------------------------------
module nl_lights_zone_ctrl
  import nl_lights_pkg::*;
#(
  parameter int unsigned NZONES      = DEF_NZONES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
`ifdef LIGHTS_DIM_EN
  , parameter int unsigned DIM_CYCLES = DEF_DIM_CYCLES
`endif
) (
  input logic                  clk,
  input logic                  reset,
  nl_lights_zone_ctrl_if.slave bus
);

  localparam int unsigned LCNT_W = $clog2(NZONES + 32'd1);

  logic [NZONES-1:0] light_vec;
  logic [NZONES-1:0] light_d_vec;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
`ifdef LIGHTS_DIM_EN
  logic [NZONES-1:0] dim_vec;
`endif

  for (genvar g = 0; g < NZONES; g++) begin : g_zone
    nl_lights_zone #(
      .HOLD_CYCLES (HOLD_CYCLES)
`ifdef LIGHTS_DIM_EN
      , .DIM_CYCLES (DIM_CYCLES)
`endif
    ) u_zone (
      .clk        (clk),
      .reset      (reset),
      .dark_i     (bus.dark),
      .movement_i (bus.movement[g]),
      .force_on_i (bus.force_on[g]),
      .light_o    (light_vec[g]),
      .light_d_o  (light_d_vec[g])
`ifdef LIGHTS_DIM_EN
      , .dim_o    (dim_vec[g])
`endif
    );
  end

  // Population count of the zones' next light values.
  always_comb begin
    lcnt_d = '0;
    for (int i = 0; i < int'(NZONES); i++) begin
      lcnt_d = lcnt_d + LCNT_W'(light_d_vec[i]);
    end
  end

  // Count register; counts next values so it updates with turn_on_lights.
  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt_q <= '0;
    end else begin
      lcnt_q <= lcnt_d;
    end
  end

  assign bus.turn_on_lights = light_vec;
  assign bus.lights_on_cnt  = lcnt_q;
`ifdef LIGHTS_DIM_EN
  assign bus.dim_lights     = dim_vec;
`endif

endmodule : nl_lights_zone_ctrl

// File: tb/tb_nl_lights_zone_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nl_lights_zone_ctrl
// Directed scoreboard bench for nl_lights_zone_ctrl with NZONES=4,
// HOLD_CYCLES=4, DIM_CYCLES=2. Each step drives inputs before an edge and
// queues the hand-computed outputs expected after that edge; a monitor pops
// and compares shortly after every rising edge. dim_lights is checked only
// when LIGHTS_DIM_EN is defined.
// ---------------------------------------------------------------------------
module tb_nl_lights_zone_ctrl;

  localparam int unsigned NZ = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  nl_lights_zone_ctrl_if #(.NZONES(NZ)) bus ();

  nl_lights_zone_ctrl #(
    .NZONES      (NZ),
    .HOLD_CYCLES (4)
`ifdef LIGHTS_DIM_EN
    , .DIM_CYCLES (2)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] lt;
    logic [2:0] cnt;
    logic [3:0] dim;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Drive one cycle of inputs and queue what must appear after the next edge.
  task automatic step(input logic r, input logic d, input logic [3:0] mv,
                      input logic [3:0] fo, input logic [3:0] exp_lt,
                      input logic [2:0] exp_cnt, input logic [3:0] exp_dim,
                      input string tag);
    exp_t e;
    @(negedge clk);
    reset        = r;
    bus.dark     = d;
    bus.movement = mv;
    bus.force_on = fo;
    e.lt  = exp_lt;
    e.cnt = exp_cnt;
    e.dim = exp_dim;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (bus.turn_on_lights !== mon_e.lt) begin
        n_errors++;
        $display("FAIL %s lights: got %b want %b", mon_e.tag, bus.turn_on_lights, mon_e.lt);
      end
      n_checks++;
      if (bus.lights_on_cnt !== mon_e.cnt) begin
        n_errors++;
        $display("FAIL %s count: got %0d want %0d", mon_e.tag, bus.lights_on_cnt, mon_e.cnt);
      end
`ifdef LIGHTS_DIM_EN
      n_checks++;
      if (bus.dim_lights !== mon_e.dim) begin
        n_errors++;
        $display("FAIL %s dim: got %b want %b", mon_e.tag, bus.dim_lights, mon_e.dim);
      end
`endif
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.dark     = 1'b1;
    bus.movement = 4'b1111;
    bus.force_on = 4'b1111;

    //    rst   dark  move     force    lights   cnt     dim      tag
    // Reset held with every input high
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 3'd0, 4'b0000, "rst0");
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 3'd0, 4'b0000, "rst1");
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000, "idle");
    // Single trigger on zone 0: on for 4 edges, dim on the last 2
    step(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 3'd1, 4'b0000, "z0_k");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 3'd1, 4'b0000, "z0_k1");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 3'd1, 4'b0001, "z0_k2");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 3'd1, 4'b0001, "z0_k3");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000, "z0_k4");
    // Retrigger at k+2 reloads the hold
    step(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 3'd1, 4'b0000, "rt_k");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 3'd1, 4'b0000, "rt_k1");
    step(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 3'd1, 4'b0000, "rt_k2");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 3'd1, 4'b0000, "rt_k3");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 3'd1, 4'b0001, "rt_k4");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 3'd1, 4'b0001, "rt_k5");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000, "rt_k6");
    // Daylight: movement alone does nothing, force_on still works
    step(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 4'b0000, "day_mv0");
    step(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 4'b0000, "day_mv1");
    step(1'b0, 1'b0, 4'b1111, 4'b0100, 4'b0100, 3'd1, 4'b0000, "day_force");
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000, "day_release");
    // Zone 1 timed, zone 2 forced, daylight returns mid-hold
    step(1'b0, 1'b1, 4'b0010, 4'b0100, 4'b0110, 3'd2, 4'b0000, "mix_start");
    step(1'b0, 1'b1, 4'b0000, 4'b0100, 4'b0110, 3'd2, 4'b0000, "mix_hold");
    step(1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0100, 3'd1, 4'b0000, "mix_daylight");
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000, "mix_off");
    // All zones at once, reset mid-hold
    step(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1111, 3'd4, 4'b0000, "all_on");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111, 3'd4, 4'b0000, "all_hold");
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 3'd0, 4'b0000, "all_reset");
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000, "post_reset");
    // Force beats movement; release with movement goes TIMED; dim never in FORCED
    step(1'b0, 1'b1, 4'b1000, 4'b1000, 4'b1000, 3'd1, 4'b0000, "z3_forced");
    step(1'b0, 1'b1, 4'b1000, 4'b0000, 4'b1000, 3'd1, 4'b0000, "z3_timed");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1000, 3'd1, 4'b0000, "z3_c3");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1000, 3'd1, 4'b1000, "z3_c2");
    step(1'b0, 1'b1, 4'b0000, 4'b1000, 4'b1000, 3'd1, 4'b0000, "z3_reforce");
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000, "z3_off");

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_nl_lights_zone_ctrl
